// File: rtl/switch_pkg.sv
// Shared switch-fabric definitions: port count, address/data widths, arbiter state type.
// Used by the VOQ arbiters and the scheduler-side blocks.
package switch_pkg;

  localparam int NPORTS = 4;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int GNT_W  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } arb_state_t;

  function automatic logic [NPORTS-1:0] onehot(input logic [GNT_W-1:0] idx);
    return {{(NPORTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/voq_arbiter_if.sv
// Bundle between one output-port arbiter, its four VOQ RAMs and its output RAM.
// The master side is the arbiter; the slave side is the RAMs plus control.
interface voq_arbiter_if import switch_pkg::*; ();

  logic                           enable;
  logic                           flush;
  logic [NPORTS-1:0][ADDR_W-1:0]  voq_wr_add;
  logic [NPORTS-1:0][ADDR_W-1:0]  voq_rd_add;
  logic [NPORTS-1:0]              voq_rden;
  logic [NPORTS-1:0][DATA_W-1:0]  voq_q;
  logic                           out_wren;
  logic [ADDR_W-1:0]              out_wr_add;
  logic [DATA_W-1:0]              out_wr_data;
  logic [ADDR_W-1:0]              out_rd_add;
  logic [DATA_W-1:0]              fwd_count;
  logic [GNT_W-1:0]               last_grant;
  logic [GNT_W-1:0]               port_tag;

  modport master (
    input  enable, flush, voq_wr_add, voq_q, out_rd_add,
    output voq_rd_add, voq_rden, out_wren, out_wr_add, out_wr_data,
           fwd_count, last_grant, port_tag
  );

  modport slave (
    output enable, flush, voq_wr_add, voq_q, out_rd_add,
    input  voq_rd_add, voq_rden, out_wren, out_wr_add, out_wr_data,
           fwd_count, last_grant, port_tag
  );

endinterface

// File: rtl/voq_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester above 'last', wrapping mod NPORTS.
module rr_pick import switch_pkg::*; (
  input  logic [NPORTS-1:0] req,
  input  logic [GNT_W-1:0]  last,
  output logic [GNT_W-1:0]  gnt,
  output logic              any
);

  logic [GNT_W-1:0] idx_s;
  logic             hit_s;

  // Walk last+1 .. last+NPORTS; the final step revisits 'last' itself.
  always_comb begin
    gnt   = last;
    any   = 1'b0;
    idx_s = last;
    hit_s = 1'b0;
    for (int k = 1; k <= NPORTS; k++) begin
      idx_s = last + GNT_W'(k);
      hit_s = !any && req[idx_s];
      gnt   = hit_s ? idx_s : gnt;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/voq_arbiter.sv
// Output-port arbiter: moves one word per 4 cycles from the round-robin selected VOQ
// into the output RAM, tracking per-VOQ read pointers and the output write pointer.
module voq_arbiter import switch_pkg::*; #(
  parameter int OUT_PORT = 0
) (
  input  logic          clk,
  input  logic          reset,
  voq_arbiter_if.master bus
);

  arb_state_t                    state_r, state_s;
  logic [NPORTS-1:0][ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W-1:0]             out_ptr_r;
  logic [DATA_W-1:0]             data_r;
  logic [DATA_W-1:0]             fwd_r;
  logic [GNT_W-1:0]              last_r;
  logic [GNT_W-1:0]              gnt_r;
  logic [GNT_W-1:0]              pick_s;
  logic [NPORTS-1:0]             req_s;
  logic [NPORTS-1:0]             rden_r;
  logic                          wren_r;
  logic                          any_s;
  logic                          full_s;
  logic                          start_s;
  logic                          capture_s;
  logic                          commit_s;

  // Occupancy: a VOQ is non-empty when its producer pointer is ahead of ours.
  always_comb begin
    req_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      req_s[i] = bus.voq_wr_add[i] != rd_ptr_r[i];
    end
    full_s = (out_ptr_r + ADDR_W'(1)) == bus.out_rd_add;
  end

  rr_pick u_pick (
    .req  (req_s),
    .last (last_r),
    .gnt  (pick_s),
    .any  (any_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-phase control strobes; flush overrides everything.
  always_comb begin
    state_s   = state_r;
    start_s   = 1'b0;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    if (bus.flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.enable && !full_s && any_s) begin
            state_s = READ;
            start_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        READ: begin
          state_s = WAIT;
        end
        WAIT: begin
          state_s   = WRITE;
          capture_s = 1'b1;
        end
        WRITE: begin
          state_s  = IDLE;
          commit_s = 1'b1;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Pointers, counters, captured word and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r  <= '0;
      out_ptr_r <= 12'd0;
      data_r    <= 32'd0;
      fwd_r     <= 32'd0;
      last_r    <= 2'd3;
      gnt_r     <= 2'd0;
      rden_r    <= 4'd0;
      wren_r    <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr_r  <= '0;
      out_ptr_r <= 12'd0;
      data_r    <= 32'd0;
      fwd_r     <= 32'd0;
      last_r    <= 2'd3;
      rden_r    <= 4'd0;
      wren_r    <= 1'b0;
    end else begin
      rden_r <= start_s ? onehot(pick_s) : 4'd0;
      wren_r <= capture_s;
      if (start_s) begin
        gnt_r <= pick_s;
      end
      if (capture_s) begin
        data_r <= bus.voq_q[gnt_r];
      end
      if (commit_s) begin
        rd_ptr_r[gnt_r] <= rd_ptr_r[gnt_r] + ADDR_W'(1);
        out_ptr_r       <= out_ptr_r + ADDR_W'(1);
        fwd_r           <= fwd_r + DATA_W'(1);
        last_r          <= gnt_r;
      end
    end
  end

  assign bus.voq_rd_add  = rd_ptr_r;
  assign bus.voq_rden    = rden_r;
  assign bus.out_wren    = wren_r;
  assign bus.out_wr_add  = out_ptr_r;
  assign bus.out_wr_data = data_r;
  assign bus.fwd_count   = fwd_r;
  assign bus.last_grant  = last_r;
  assign bus.port_tag    = GNT_W'(OUT_PORT);

endmodule

// File: tb/tb_voq_arbiter.sv
// Directed bench for voq_arbiter: expected output-RAM writes are queued by the
// stimulus and popped by an independent monitor whenever out_wren is seen.
module tb_voq_arbiter;
  import switch_pkg::*;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb_q[$];
  logic [DATA_W-1:0] voq_mem [NPORTS][4096];

  voq_arbiter_if bus();

  voq_arbiter #(.OUT_PORT(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // VOQ RAM model: one-cycle read latency.
  always @(posedge clk) begin
    for (int i = 0; i < NPORTS; i++) begin
      if (bus.voq_rden[i]) bus.voq_q[i] <= voq_mem[i][bus.voq_rd_add[i]];
    end
  end

  function automatic logic [DATA_W-1:0] pat(input int i, input int a);
    return {4'(i + 1), 16'h0000, 12'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input int addr, input logic [DATA_W-1:0] data, input int at_cyc);
    exp_t e;
    e.addr = 12'(addr);
    e.data = data;
    e.cyc  = at_cyc;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.flush      = 1'b0;
    bus.voq_wr_add = '0;
    bus.out_rd_add = 12'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_fwd(input int target, input int budget, input string name);
    int n = 0;
    while (bus.fwd_count != 32'(target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.fwd_count, 32'(target));
  endtask

  // Monitor: every output-RAM write must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) begin
      if ($countones(bus.voq_rden) > 1) begin
        n_vec++;
        n_bad++;
        $display("FAIL rden_onehot: got %b, want at most one bit", bus.voq_rden);
      end
      if (bus.out_wren) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h, want no write", bus.out_wr_add, bus.out_wr_data);
        end else begin
          e = sb_q.pop_front();
          chk("wr_add", 32'(bus.out_wr_add), 32'(e.addr));
          chk("wr_data", bus.out_wr_data, e.data);
          if (e.cyc >= 0) chk("wr_latency_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish before time limit");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NPORTS; i++)
      for (int a = 0; a < 4096; a++) voq_mem[i][a] = pat(i, a);

    // Reset values and quiet first cycle after release.
    do_reset();
    #1;
    chk("rst_rden", 32'(bus.voq_rden), 32'd0);
    chk("rst_wren", 32'(bus.out_wren), 32'd0);
    chk("rst_wr_add", 32'(bus.out_wr_add), 32'd0);
    chk("rst_wr_data", bus.out_wr_data, 32'd0);
    for (int i = 0; i < NPORTS; i++) chk($sformatf("rst_rd_add%0d", i), 32'(bus.voq_rd_add[i]), 32'd0);
    @(negedge clk);
    chk("rst_fwd", bus.fwd_count, 32'd0);
    chk("rst_last", 32'(bus.last_grant), 32'd3);
    chk("port_tag", 32'(bus.port_tag), 32'd0);

    // Single word from VOQ 2: out_wren 3 cycles after the VOQ turns non-empty.
    voq_mem[2][0] = 32'hDEADBEEF;
    bus.enable = 1'b1;
    push(0, 32'hDEADBEEF, cyc + 3);
    bus.voq_wr_add[2] = 12'd1;
    wait_fwd(1, 20, "t1_fwd");
    chk("t1_last", 32'(bus.last_grant), 32'd2);
    chk("t1_rd_add2", 32'(bus.voq_rd_add[2]), 32'd1);
    repeat (5) @(negedge clk);
    chk("t1_fwd_hold", bus.fwd_count, 32'd1);

    // Two words in every VOQ: strict round robin 0,1,2,3,0,1,2,3.
    do_reset();
    voq_mem[2][0] = pat(2, 0);
    for (int j = 0; j < 8; j++) push(j, pat(j % 4, j / 4), -1);
    bus.enable = 1'b1;
    for (int i = 0; i < NPORTS; i++) bus.voq_wr_add[i] = 12'd2;
    wait_fwd(8, 60, "t2_fwd");
    chk("t2_last", 32'(bus.last_grant), 32'd3);
    for (int i = 0; i < NPORTS; i++) chk($sformatf("t2_rd_add%0d", i), 32'(bus.voq_rd_add[i]), 32'd2);

    // Output full at out_ptr=4 with out_rd_add=5; releases when out_rd_add moves to 6.
    do_reset();
    bus.enable = 1'b1;
    bus.out_rd_add = 12'd5;
    for (int k = 0; k < 4; k++) push(k, pat(0, k), -1);
    bus.voq_wr_add[0] = 12'd6;
    wait_fwd(4, 40, "t3_fwd4");
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_full_no_rden", 32'(bus.voq_rden), 32'd0);
    end
    push(4, pat(0, 4), -1);
    bus.out_rd_add = 12'd6;
    @(negedge clk);
    chk("t3_resume_rden", 32'(bus.voq_rden), 32'b0001);
    wait_fwd(5, 20, "t3_fwd5");
    repeat (10) @(negedge clk);
    chk("t3_full_again", bus.fwd_count, 32'd5);

    // Pointer wrap on VOQ 1: 4095 words, then the word at address 4095.
    do_reset();
    bus.enable = 1'b1;
    for (int a = 0; a < 4095; a++) push(a, pat(1, a), -1);
    bus.voq_wr_add[1] = 12'd4095;
    wait_fwd(4095, 4095 * 4 + 50, "t4_fwd4095");
    chk("t4_rd_ptr4095", 32'(bus.voq_rd_add[1]), 32'd4095);
    bus.out_rd_add = 12'd2048;
    push(4095, pat(1, 4095), -1);
    bus.voq_wr_add[1] = 12'd0;
    wait_fwd(4096, 20, "t4_fwd4096");
    repeat (10) @(negedge clk);
    chk("t4_rd_ptr_wrapped", 32'(bus.voq_rd_add[1]), 32'd0);
    chk("t4_empty_fwd", bus.fwd_count, 32'd4096);
    chk("t4_empty_rden", 32'(bus.voq_rden), 32'd0);

    // Flush during WAIT: transfer dropped, state cleared, input 0 served next.
    do_reset();
    bus.enable = 1'b1;
    bus.voq_wr_add[3] = 12'd1;
    @(negedge clk);
    chk("t5_rden3", 32'(bus.voq_rden), 32'b1000);
    @(negedge clk);
    push(0, pat(0, 0), -1);
    push(1, pat(3, 0), -1);
    bus.flush = 1'b1;
    bus.voq_wr_add[0] = 12'd1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("t5_wren", 32'(bus.out_wren), 32'd0);
    chk("t5_fwd", bus.fwd_count, 32'd0);
    chk("t5_last", 32'(bus.last_grant), 32'd3);
    chk("t5_wr_add", 32'(bus.out_wr_add), 32'd0);
    chk("t5_wr_data", bus.out_wr_data, 32'd0);
    chk("t5_rd_add3", 32'(bus.voq_rd_add[3]), 32'd0);
    wait_fwd(2, 30, "t5_fwd2");
    chk("t5_last_after", 32'(bus.last_grant), 32'd3);

    // Asynchronous reset in the middle of WRITE.
    do_reset();
    bus.enable = 1'b1;
    push(0, pat(1, 0), cyc + 3);
    bus.voq_wr_add[1] = 12'd1;
    repeat (3) @(negedge clk);
    chk("t6_wren_before", 32'(bus.out_wren), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_wren", 32'(bus.out_wren), 32'd0);
    chk("t6_rden", 32'(bus.voq_rden), 32'd0);
    chk("t6_wr_add", 32'(bus.out_wr_add), 32'd0);
    chk("t6_wr_data", bus.out_wr_data, 32'd0);
    chk("t6_fwd", bus.fwd_count, 32'd0);
    chk("t6_last", 32'(bus.last_grant), 32'd3);
    chk("t6_rd_add1", 32'(bus.voq_rd_add[1]), 32'd0);
    do_reset();
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/voq_arbiter.md
VOQ_ARBITER -- requirements
Module: voq_arbiter

Interface
REQ-001 Parameter OUT_PORT, default 0: index (0-3) of the output port this instance serves; affects only the status tag.
REQ-002 clk  in  1: sole clock; all state advances on its rising edge.
REQ-003 reset  in  1: asynchronous, active-high reset.
REQ-004 enable  in  1: level; high permits new grants (driven by the top-level read_enable).
REQ-005 flush  in  1: one-cycle synchronous pulse; clears all pointers (driven by reset_rams).
REQ-006 voq_wr_add  in  4x12: write address of each VOQ RAM (input i -> this output). This is the producer pointer.
REQ-007 voq_rd_add  out  4x12: read address to each VOQ RAM.
REQ-008 voq_rden  out  4x1: read enable to each VOQ RAM; at most one bit is high in any cycle.
REQ-009 voq_q  in  4x32: VOQ RAM read data, valid exactly 1 cycle after rden.
REQ-010 out_wren  out  1: write strobe to the output RAM.
REQ-011 out_wr_add  out  12: output RAM write address.
REQ-012 out_wr_data  out  32: output RAM write data.
REQ-013 out_rd_add  in  12: consumer read pointer of the output RAM, used for the full check.
REQ-014 fwd_count  out  32: total words forwarded since reset or flush.
REQ-015 last_grant  out  2: index of the input most recently served.

Function
REQ-016 VOQ i is non-empty when voq_wr_add[i] != rd_ptr[i]; all pointer compares are 12-bit and wrap naturally from 4095 to 0.
REQ-017 The output is full when (out_ptr + 1) mod 4096 == out_rd_add; a full output holds the FSM in IDLE.
REQ-018 FSM states are IDLE, READ, WAIT and WRITE.
REQ-019 IDLE -> READ occurs when enable=1, the output is not full, and any VOQ is non-empty; the grant g is latched in this transition.
REQ-020 Grant rule is round-robin: search from last_grant+1 upward, mod 4; the first non-empty VOQ wins.
REQ-021 READ: voq_rden[g]=1 and voq_rd_add[g]=rd_ptr[g] for one cycle, then go to WAIT.
REQ-022 WAIT: capture voq_q[g] into the data register, then go to WRITE.
REQ-023 WRITE: out_wren=1, out_wr_add=out_ptr, out_wr_data=captured word, all for one cycle.
REQ-024 WRITE also updates state: rd_ptr[g]++, out_ptr++, fwd_count++, last_grant<=g; then go to IDLE.
REQ-025 Throughput is one word per 4 cycles; latency from a non-empty VOQ in IDLE to out_wren is 3 cycles.
REQ-026 voq_rd_add[i] continuously equals rd_ptr[i] for all i.
REQ-027 enable dropping mid-transfer does not abort it; the transfer completes and the FSM parks in IDLE.
REQ-028 flush (any state) zeroes rd_ptr[0..3], out_ptr, fwd_count and the data register.
REQ-029 flush also sets last_grant=3, forces IDLE, and deasserts all strobes next cycle; flush takes priority over WRITE in the same cycle.
REQ-030 A VOQ write that coincides with its read is permitted; emptiness uses the current voq_wr_add only.
REQ-031 fwd_count wraps at 2^32 silently.

Reset
REQ-032 On reset: state=IDLE; rd_ptr, out_ptr, fwd_count, data register=0; last_grant=3 (so input 0 is served first).
REQ-033 On reset: voq_rden=0, out_wren=0, out_wr_add=0, out_wr_data=0, voq_rd_add=0.
REQ-034 Reset release is glitch-free; no strobe asserts in the first cycle after deassertion.

Structure
REQ-035 switch_pkg holds NPORTS=4, ADDR_W=12, DATA_W=32 and the typedef arb_state_t {IDLE, READ, WAIT, WRITE}; the same package is shared with scheduler-side blocks.
REQ-036 The round-robin search is a combinational sub-module, rr_pick: inputs req[3:0] and last[1:0]; outputs gnt[1:0] and any.
REQ-037 Four instances, OUT_PORT 0-3, form the 4x4 VOQ fabric.

Verification
REQ-038 After reset with enable=1: voq_wr_add[2]=1 with voq_q[2]=0xDEADBEEF -> out_wren 3 cycles later, out_wr_add=0, data=0xDEADBEEF, last_grant=2, fwd_count=1.
REQ-039 All four VOQs hold 2 words -> 8 writes, grant order 0,1,2,3,0,1,2,3, out_wr_add 0..7.
REQ-040 out_rd_add=5 with out_ptr=4 -> no rden issued; raising out_rd_add to 6 -> transfer resumes within 1 cycle.
REQ-041 Wrap test: rd_ptr[1]=4095 and voq_wr_add[1]=0 -> one word read at address 4095, then rd_ptr[1]=0 and VOQ 1 empty.
REQ-042 flush asserted in WAIT -> no out_wren; all pointers and fwd_count=0; next grant goes to input 0.
REQ-043 reset asserted mid-WRITE asynchronously -> out_wren drops immediately; all outputs at reset values.
